// File: rtl/carrd_issue_queue_if.sv
// carrd_issue_queue_if: push channel from the scalar base processor into the
// vector issue queue (instruction plus its two scalar operands, valid/ready).
// master = base processor side, slave = issue queue side.
interface carrd_issue_queue_if;
   logic [31:0] instr_in;     // vector instruction
   logic [31:0] xreg1_in;     // rs1 value captured with the instruction
   logic [31:0] xreg2_in;     // rs2 value captured with the instruction
   logic        instr_valid;  // upstream has an instruction
   logic        instr_ready;  // queue can accept (not full)

   modport master (
      output instr_in, xreg1_in, xreg2_in, instr_valid,
      input  instr_ready
   );

   modport slave (
      input  instr_in, xreg1_in, xreg2_in, instr_valid,
      output instr_ready
   );
endinterface

// File: rtl/carrd_issue_queue.sv
// carrd_issue_queue: FIFO of {xreg2, xreg1, instr} between the base processor and
// the vector coprocessor. One instruction at a time is held on op_instr_base /
// xreg_out1 / xreg_out2 until it completes, then an all-zero bubble cycle follows.
// Ports: clk, nrst (async active-low); up (push channel, slave modport);
//   op_instr_base/xreg_out1/xreg_out2 (held issue outputs, 0 when idle);
//   done_in (OR of coprocessor done flags); busy; count (FIFO occupancy);
//   err (sticky watchdog abort, only when ISSUE_TIMEOUT_EN is defined).
// Optional feature macro: ISSUE_TIMEOUT_EN (8-bit EXEC watchdog plus err port).
module carrd_issue_queue #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   nrst,
   carrd_issue_queue_if.slave     up,
   output logic [31:0]            op_instr_base,
   output logic [31:0]            xreg_out1,
   output logic [31:0]            xreg_out2,
   input  logic                   done_in,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
`ifdef ISSUE_TIMEOUT_EN
   ,
   output logic                   err
`endif
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [95:0] mem [DEPTH];
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic        finish;
   logic        is_cfg;
   logic        complete;

   // Pointers carry one extra wrap bit: equal means empty, differing only in
   // the wrap bit means full.
   assign empty          = (wr_ptr == rd_ptr);
   assign full           = (wr_ptr[AW] != rd_ptr[AW]) &&
                           (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign up.instr_ready = !full;
   assign push           = up.instr_valid && !full;
   assign count          = wr_ptr - rd_ptr;
   assign busy           = (state == EXEC) || !empty;

   // vset{i}vl{i} has no functional-unit done flag; it retires on its first
   // EXEC cycle.
   assign is_cfg = (op_instr_base[6:0] == 7'b1010111) &&
                   (op_instr_base[14:12] == 3'b111);

`ifdef ISSUE_TIMEOUT_EN
   logic [7:0] wd_cnt;
   logic       timeout;

   // The counter is 0 in the first EXEC cycle, so sampling 254 marks the
   // 255th EXEC cycle; leaving on that edge bounds EXEC to 255 cycles.
   assign timeout  = (wd_cnt == 8'd254);
   assign complete = is_cfg || done_in || timeout;
`else
   assign complete = is_cfg || done_in;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // IDLE always lasts at least one cycle after EXEC, which gives the
   // all-zero bubble between instructions.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      finish    = 1'b0;
      if (state == IDLE) begin
         if (!empty) begin
            pop       = 1'b1;
            state_nxt = EXEC;
         end
      end else begin
         if (complete) begin
            finish    = 1'b1;
            state_nxt = IDLE;
         end
      end
   end

   // Storage needs no reset: reset clears the pointers, so no stale entry is
   // ever visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {up.xreg2_in, up.xreg1_in, up.instr_in};
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         op_instr_base <= '0;
         xreg_out1     <= '0;
         xreg_out2     <= '0;
      end else if (pop) begin
         {xreg_out2, xreg_out1, op_instr_base} <= mem[rd_ptr[AW-1:0]];
      end else if (finish) begin
         op_instr_base <= '0;
         xreg_out1     <= '0;
         xreg_out2     <= '0;
      end
   end

`ifdef ISSUE_TIMEOUT_EN
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wd_cnt <= '0;
         err    <= 1'b0;
      end else begin
         if (pop) begin
            wd_cnt <= '0;
         end else if (state == EXEC) begin
            wd_cnt <= wd_cnt + 8'd1;
         end
         // Only a genuine abort is flagged; a done on the same edge wins.
         if ((state == EXEC) && timeout && !is_cfg && !done_in) begin
            err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_carrd_issue_queue.sv
module tb_carrd_issue_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [31:0] VADD  = 32'h0220_8057;
   localparam logic [31:0] VADD2 = 32'h0241_0057;
   localparam logic [31:0] VSET  = 32'h00C0_7057;

   logic          clk = 1'b0;
   logic          nrst;
   logic [31:0]   op_instr_base;
   logic [31:0]   xreg_out1;
   logic [31:0]   xreg_out2;
   logic          done_in;
   logic          busy;
   logic [CW-1:0] count;
`ifdef ISSUE_TIMEOUT_EN
   logic          err;
`endif

   carrd_issue_queue_if bus();

   carrd_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .nrst          (nrst),
      .up            (bus),
      .op_instr_base (op_instr_base),
      .xreg_out1     (xreg_out1),
      .xreg_out2     (xreg_out2),
      .done_in       (done_in),
      .busy          (busy),
      .count         (count)
`ifdef ISSUE_TIMEOUT_EN
      ,
      .err           (err)
`endif
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [95:0] sb[$];
   logic [95:0] prev_out = '0;
   logic [95:0] cur_out;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [CW+97:0] outs();
      return {bus.instr_ready, count, busy, op_instr_base, xreg_out1, xreg_out2};
   endfunction

   function automatic logic [CW+97:0] pk(input logic rdy, input logic [CW-1:0] cnt, input logic bsy,
                                         input logic [31:0] op, input logic [31:0] x1, input logic [31:0] x2);
      return {rdy, cnt, bsy, op, x1, x2};
   endfunction

   // Scoreboard producer: every accepted push is expected to issue, in order.
   always @(posedge clk) begin
      if (nrst && bus.instr_valid && bus.instr_ready)
         sb.push_back({bus.xreg2_in, bus.xreg1_in, bus.instr_in});
   end

   // Scoreboard consumer: a new issue follows a zero cycle; held values stay stable.
   always @(posedge clk) begin
      #1;
      if (!nrst) begin
         prev_out = '0;
      end else begin
         cur_out = {xreg_out2, xreg_out1, op_instr_base};
         if (op_instr_base == 32'd0)
            check("zero_when_idle", {32'd0, cur_out}, 128'd0);
         else if (prev_out[31:0] == 32'd0) begin
            if (sb.size() == 0) check("issue_unexpected", {32'd0, cur_out}, 128'd0);
            else                check("issue_order", {32'd0, cur_out}, {32'd0, sb.pop_front()});
         end else
            check("issue_hold_or_bubble", {32'd0, cur_out}, {32'd0, prev_out});
         prev_out = cur_out;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] x1, input logic [31:0] x2);
      bus.instr_valid = v;
      bus.instr_in    = i;
      bus.xreg1_in    = x1;
      bus.xreg2_in    = x2;
   endtask

   task automatic drain();
      int n;
      n = 0;
      done_in = 1'b1;
      while (busy && n < 60) begin
         cyc();
         n++;
      end
      check("drain_bounded", {127'd0, busy}, 128'd0);
      done_in = 1'b0;
      cyc();
      check("sb_empty", sb.size(), 128'd0);
   endtask

   typedef struct {
      logic          vld;
      logic [31:0]   instr;
      logic [31:0]   x1;
      logic [31:0]   x2;
      logic          done;
      logic          rdy;
      logic [CW-1:0] cnt;
      logic          bsy;
      logic [31:0]   op;
      logic [31:0]   xo1;
      logic [31:0]   xo2;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                               input logic d, input logic r, input logic [CW-1:0] c, input logic bs,
                               input logic [31:0] o, input logic [31:0] o1, input logic [31:0] o2);
      vec_t t;
      t.vld = v; t.instr = i; t.x1 = a; t.x2 = b; t.done = d;
      t.rdy = r; t.cnt = c; t.bsy = bs; t.op = o; t.xo1 = o1; t.xo2 = o2;
      return t;
   endfunction

   vec_t        tbl[13];
   logic [31:0] ins[8];

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int n;
      // Expected outputs are the state after the edge each row is applied to.
      tbl[0]  = mk(1, VADD,  5, 7, 0,  1, 1, 1, 0,     0, 0);
      tbl[1]  = mk(0, 0,     0, 0, 0,  1, 0, 1, VADD,  5, 7);
      tbl[2]  = mk(0, 0,     0, 0, 0,  1, 0, 1, VADD,  5, 7);
      tbl[3]  = mk(0, 0,     0, 0, 0,  1, 0, 1, VADD,  5, 7);
      tbl[4]  = mk(0, 0,     0, 0, 0,  1, 0, 1, VADD,  5, 7);
      tbl[5]  = mk(0, 0,     0, 0, 1,  1, 0, 0, 0,     0, 0);
      tbl[6]  = mk(0, 0,     0, 0, 1,  1, 0, 0, 0,     0, 0);
      tbl[7]  = mk(1, VSET,  1, 2, 0,  1, 1, 1, 0,     0, 0);
      tbl[8]  = mk(1, VADD2, 3, 4, 0,  1, 1, 1, VSET,  1, 2);
      tbl[9]  = mk(0, 0,     0, 0, 0,  1, 1, 1, 0,     0, 0);
      tbl[10] = mk(0, 0,     0, 0, 0,  1, 0, 1, VADD2, 3, 4);
      tbl[11] = mk(0, 0,     0, 0, 0,  1, 0, 1, VADD2, 3, 4);
      tbl[12] = mk(0, 0,     0, 0, 1,  1, 0, 0, 0,     0, 0);
      for (int k = 0; k < 8; k++) ins[k] = 32'h0200_0057 | (32'(k + 1) << 7);

      nrst = 1'b0;
      done_in = 1'b0;
      drive(0, 0, 0, 0);
      cyc();
      cyc();
      check("reset_state", outs(), pk(1, 0, 0, 0, 0, 0));
      nrst = 1'b1;
      cyc();
      cyc();
      check("idle_state", outs(), pk(1, 0, 0, 0, 0, 0));

      // Single vadd held 4 cycles, then vsetvli retiring in one cycle.
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].vld, tbl[i].instr, tbl[i].x1, tbl[i].x2);
         done_in = tbl[i].done;
         cyc();
         check($sformatf("vec%0d", i), outs(),
               pk(tbl[i].rdy, tbl[i].cnt, tbl[i].bsy, tbl[i].op, tbl[i].xo1, tbl[i].xo2));
      end
      drive(0, 0, 0, 0);
      done_in = 1'b0;
      cyc();

      // Fill: six back-to-back pushes, A executes, B..E stored, F refused.
      for (int k = 0; k < 6; k++) begin
         drive(1, ins[k], 32'(k + 10), 32'(k + 20));
         cyc();
      end
      check("full_after_fill", outs(), pk(0, 4, 1, ins[0], 10, 20));
      cyc();
      check("full_stays", outs(), pk(0, 4, 1, ins[0], 10, 20));
      done_in = 1'b1;
      cyc();
      check("a_done_still_full", outs(), pk(0, 4, 1, 0, 0, 0));
      done_in = 1'b0;
      cyc();
      check("ready_after_pop", outs(), pk(1, 3, 1, ins[1], 11, 21));
      cyc();
      check("f_pushed_full", outs(), pk(0, 4, 1, ins[1], 11, 21));
      drive(0, 0, 0, 0);
      done_in = 1'b1;
      cyc();
      done_in = 1'b0;
      cyc();
      check("c_popped", outs(), pk(1, 3, 1, ins[2], 12, 22));
      done_in = 1'b1;
      cyc();
      done_in = 1'b0;
      check("c_done_idle", outs(), pk(1, 3, 1, 0, 0, 0));
      // Push G on the same edge D is popped: occupancy unchanged, pointers wrap.
      drive(1, ins[6], 16, 26);
      cyc();
      check("push_pop_same_edge", outs(), pk(1, 3, 1, ins[3], 13, 23));
      drive(0, 0, 0, 0);
      drain();

      // Reset in the middle of EXEC flushes everything asynchronously.
      drive(1, ins[7], 17, 27);
      cyc();
      drive(1, ins[0], 30, 40);
      cyc();
      drive(0, 0, 0, 0);
      check("exec_before_reset", {96'd0, op_instr_base}, {96'd0, ins[7]});
      #3;
      nrst = 1'b0;
      #1;
      check("async_reset_outputs", outs(), pk(1, 0, 0, 0, 0, 0));
      sb.delete();
      cyc();
      nrst = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      check("no_entry_survives", outs(), pk(1, 0, 0, 0, 0, 0));

`ifdef ISSUE_TIMEOUT_EN
      check("err_clear", {127'd0, err}, 128'd0);
      drive(1, ins[4], 1, 2);
      cyc();
      drive(1, ins[5], 3, 4);
      cyc();
      drive(0, 0, 0, 0);
      n = 0;
      while (op_instr_base == ins[4] && n < 400) begin
         n++;
         cyc();
      end
      check("timeout_cycles", n, 128'd255);
      check("err_set", {127'd0, err}, 128'd1);
      cyc();
      check("next_after_timeout", {96'd0, op_instr_base}, {96'd0, ins[5]});
      nrst = 1'b0;
      sb.delete();
      #1;
      check("err_reset", {127'd0, err}, 128'd0);
      cyc();
      nrst = 1'b1;
      cyc();
`else
      n = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
